// File: rtl/ncl_adder_sequencer.sv
// Clocked sequencer for a dual-rail NCL ripple adder: DATA/NULL wavefront control with valid/ready.
// Optional watchdog on DATA and WAIT_NULL waits is enabled by defining NCL_SEQ_TIMEOUT_EN.
module ncl_adder_sequencer #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             err,
   output logic [WIDTH-1:0] at,
   output logic [WIDTH-1:0] af,
   output logic [WIDTH-1:0] bt,
   output logic [WIDTH-1:0] bf,
   output logic             cint,
   output logic             cinf,
   input  logic [WIDTH-1:0] st,
   input  logic [WIDTH-1:0] sf,
   input  logic             coutt,
   input  logic             coutf
);

   typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_DATA, S_WAIT_NULL, S_ERR} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] at_q, at_d, af_q, af_d, bt_q, bt_d, bf_q, bf_d;
   logic             cint_q, cint_d, cinf_q, cinf_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q, in_ready_d;
   logic             err_q, err_d;

   // Adder outputs are asynchronous to clk; the FSM only ever looks at the second stage.
   logic [WIDTH:0]   t_s1_q, t_s2_q, f_s1_q, f_s2_q;
   logic             sync_illegal, sync_complete, sync_null, timeout_hit;

   always_ff @(posedge clk) begin
      t_s1_q <= {coutt, st};
      f_s1_q <= {coutf, sf};
      t_s2_q <= t_s1_q;
      f_s2_q <= f_s1_q;
   end

   assign sync_illegal  = |(t_s2_q & f_s2_q);
   assign sync_complete = &(t_s2_q ^ f_s2_q);
   assign sync_null     = ~|(t_s2_q | f_s2_q);

`ifdef NCL_SEQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q;

   // Any state change clears the counter, so it restarts on every DATA / WAIT_NULL entry.
   always_ff @(posedge clk) begin
      if (rst || (state_d != state_q))
         cnt_q <= '0;
      else if (state_q == S_DATA || state_q == S_WAIT_NULL)
         cnt_q <= cnt_q + CNT_W'(1);
   end

   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      at_d        = at_q;
      af_d        = af_q;
      bt_d        = bt_q;
      bf_d        = bf_q;
      cint_d      = cint_q;
      cinf_d      = cinf_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      err_d       = err_q;
      out_valid_d = out_valid_q;
      if (out_valid_q && out_ready)
         out_valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               at_d    = a;
               af_d    = ~a;
               bt_d    = b;
               bf_d    = ~b;
               cint_d  = cin;
               cinf_d  = ~cin;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (sync_illegal || timeout_hit) begin
               err_d   = 1'b1;
               state_d = S_ERR;
            end else if (sync_complete) begin
               sum_d       = t_s2_q[WIDTH-1:0];
               cout_d      = t_s2_q[WIDTH];
               out_valid_d = 1'b1;
               state_d     = S_WAIT_NULL;
            end
         end
         S_WAIT_NULL: begin
            if (sync_illegal || timeout_hit) begin
               err_d   = 1'b1;
               state_d = S_ERR;
            end else if (sync_null) begin
               state_d = S_IDLE;
            end
         end
         S_ERR: begin
            out_valid_d = out_valid_q;
         end
         default: begin
            if (sync_null)
               state_d = S_IDLE;
         end
      endcase

      // Rails are only ever non-NULL while the FSM sits in DATA.
      if (state_d != S_DATA) begin
         at_d   = '0;
         af_d   = '0;
         bt_d   = '0;
         bf_d   = '0;
         cint_d = 1'b0;
         cinf_d = 1'b0;
      end

      in_ready_d = (state_d == S_IDLE) && !out_valid_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_FLUSH;
         at_q        <= '0;
         af_q        <= '0;
         bt_q        <= '0;
         bf_q        <= '0;
         cint_q      <= 1'b0;
         cinf_q      <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         at_q        <= at_d;
         af_q        <= af_d;
         bt_q        <= bt_d;
         bf_q        <= bf_d;
         cint_q      <= cint_d;
         cinf_q      <= cinf_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         err_q       <= err_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign err       = err_q;
   assign at        = at_q;
   assign af        = af_q;
   assign bt        = bt_q;
   assign bf        = bf_q;
   assign cint      = cint_q;
   assign cinf      = cinf_q;

endmodule
